// File: rtl/unified_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_if
//   Bundles every non-clock/reset signal of unified_mem_arbiter: the fetch
//   queue head toward IF/ID, pipeline control (flush/halt), the MEM-stage
//   data request, and the single-port memory bus.
//
//   modport master : the arbiter's view (drives if_*, d_ack/d_rdata, m_*, fq_count)
//   modport slave  : the environment's view (pipeline plus memory)
//
//   Signal summary
//     if_valid/if_ready/if_instr/if_pc : fetch-queue head handshake
//     flush/flush_pc                   : fetch redirect
//     halt                             : stop issuing fetches
//     d_req/d_we/d_addr/d_wdata/d_funct3, d_ack/d_rdata : data access
//     m_addr/m_re/m_we/m_wdata/m_funct3, m_rdata        : memory bus
//     fq_count                         : fetch-queue occupancy
// ---------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 8,
  parameter int FQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  // Fetch queue head toward IF/ID
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_instr;
  logic [XLEN-1:0]   if_pc;

  // Pipeline control
  logic              flush;
  logic [XLEN-1:0]   flush_pc;
  logic              halt;

  // MEM-stage data path
  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [2:0]        d_funct3;
  logic              d_ack;
  logic [XLEN-1:0]   d_rdata;

  // Shared single-port memory
  logic [ADDR_W-1:0] m_addr;
  logic              m_re;
  logic              m_we;
  logic [XLEN-1:0]   m_wdata;
  logic [2:0]        m_funct3;
  logic [XLEN-1:0]   m_rdata;

  // Status
  logic [CNT_W-1:0]  fq_count;

  modport master (
    output if_valid, if_instr, if_pc,
    input  if_ready,
    input  flush, flush_pc, halt,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    output d_ack, d_rdata,
    output m_addr, m_re, m_we, m_wdata, m_funct3,
    input  m_rdata,
    output fq_count
  );

  modport slave (
    input  if_valid, if_instr, if_pc,
    output if_ready,
    output flush, flush_pc, halt,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    input  d_ack, d_rdata,
    input  m_addr, m_re, m_we, m_wdata, m_funct3,
    output m_rdata,
    input  fq_count
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares one single-port memory between a prefetching instruction-fetch
//   path and the MEM-stage data path. Data accesses win arbitration, except
//   that after STARVE_MAX consecutive data grants with an empty fetch queue
//   one fetch grant is forced. Fetched words are buffered in an FQ_DEPTH-entry
//   FIFO that feeds the IF/ID register. Supports flush-to-target and halt.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : unified_mem_arbiter_if.master (fetch head, control, data, memory)
//
//   Parameters
//     XLEN       data/PC width
//     ADDR_W     memory byte-address width (m_addr = addr[ADDR_W-1:0])
//     FQ_DEPTH   fetch-queue entries, power of 2, >= 2
//     STARVE_MAX data grants tolerated with an empty queue before a forced fetch
//     RESET_PC   fetch PC after reset
//
//   Build option
//     FQ_BYPASS_EN : when defined, a word fetched into an empty queue while
//                    IF/ID is ready is presented combinationally the same
//                    cycle instead of being enqueued. When undefined, the
//                    head outputs come only from queue registers.
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int              XLEN       = 32,
  parameter int              ADDR_W     = 8,
  parameter int              FQ_DEPTH   = 4,
  parameter int              STARVE_MAX = 3,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(FQ_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_LIM   = SC_W'(STARVE_MAX);
  localparam logic [2:0]       FETCH_FUNCT3 = 3'b010;
  localparam logic [XLEN-1:0]  PC_STEP      = XLEN'(4);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0]  r_fetch_pc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [SC_W-1:0]  r_starve_cnt;
  logic [XLEN-1:0]  r_q_instr [FQ_DEPTH];
  logic [XLEN-1:0]  r_q_pc    [FQ_DEPTH];

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_force_f;
  logic w_grant_d;
  logic w_grant_f;
  logic w_fetch_go;   // fetch grant whose word is kept (not killed by flush)
  logic w_enq;
  logic w_deq;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A data request is refused only when the fetch side has been starved long
  // enough with nothing buffered; halt suppresses the forced fetch entirely.
  assign w_force_f  = w_empty & (r_starve_cnt == STARVE_LIM) & ~bus.halt;
  assign w_grant_d  = bus.d_req & ~w_force_f;
  // A full queue never fetches, even when the head drains this cycle.
  assign w_grant_f  = ~w_grant_d & ~bus.halt & ~w_full;
  assign w_fetch_go = w_grant_f & ~bus.flush;

  // Flush empties the queue, so a dequeue in the same cycle must not move
  // the read pointer or the count.
  assign w_deq = ~w_empty & bus.if_ready & ~bus.flush;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.m_addr   = r_fetch_pc[ADDR_W-1:0];
    bus.m_re     = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_wdata  = bus.d_wdata;
    bus.m_funct3 = FETCH_FUNCT3;
    if (w_grant_d) begin
      bus.m_addr   = bus.d_addr[ADDR_W-1:0];
      bus.m_re     = ~bus.d_we;
      bus.m_we     = bus.d_we;
      bus.m_funct3 = bus.d_funct3;
    end else if (w_grant_f) begin
      bus.m_re = 1'b1;
    end
  end

  assign bus.d_ack    = w_grant_d;
  assign bus.d_rdata  = bus.m_rdata;
  assign bus.fq_count = r_count;

  // -------------------------------------------------------------------------
  // Head presentation (optional same-cycle bypass)
  // -------------------------------------------------------------------------
`ifdef FQ_BYPASS_EN
  logic w_bypass;

  // The word goes straight to IF/ID only if nothing older is queued and the
  // consumer takes it now; otherwise it is buffered as usual.
  assign w_bypass = w_empty & w_fetch_go & bus.if_ready;
  assign w_enq    = w_fetch_go & ~w_bypass;

  always_comb begin
    bus.if_valid = ~w_empty;
    bus.if_instr = r_q_instr[r_rd_ptr];
    bus.if_pc    = r_q_pc[r_rd_ptr];
    if (w_bypass) begin
      bus.if_valid = 1'b1;
      bus.if_instr = bus.m_rdata;
      bus.if_pc    = r_fetch_pc;
    end
  end
`else
  assign w_enq        = w_fetch_go;
  assign bus.if_valid = ~w_empty;
  assign bus.if_instr = r_q_instr[r_rd_ptr];
  assign bus.if_pc    = r_q_pc[r_rd_ptr];
`endif

  // -------------------------------------------------------------------------
  // Control state: fetch PC, queue pointers/count, starvation counter
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
    end else if (bus.flush) begin
      // Redirect dominates all queue activity; a granted data access in the
      // same cycle still completes combinationally.
      r_fetch_pc   <= {bus.flush_pc[XLEN-1:2], 2'b00};
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant_f) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end

      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - CNT_W'(1);
      end

      // Only data grants against an empty queue count as starvation.
      if (w_grant_f || !w_empty) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Queue storage
  // -------------------------------------------------------------------------
  // NOTE: the entries are reset so the head outputs read 0 before the first
  // enqueue; this keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_enq) begin
      r_q_instr[r_wr_ptr] <= bus.m_rdata;
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
//   Directed bench for unified_mem_arbiter in its default build. Models a
//   64-word memory (word i preloaded with 0x11*(i+1)), read combinationally
//   from m_addr and written one cycle-edge after m_we is seen.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int XLEN       = 32;
  localparam int ADDR_W     = 8;
  localparam int FQ_DEPTH   = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ_DEPTH)) bus ();

  unified_mem_arbiter #(
    .XLEN      (XLEN),
    .ADDR_W    (ADDR_W),
    .FQ_DEPTH  (FQ_DEPTH),
    .STARVE_MAX(STARVE_MAX),
    .RESET_PC  ('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [64];
  assign bus.m_rdata = mem[bus.m_addr[7:2]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; a store seen before the edge lands in memory after it.
  task automatic tick();
    logic        wen;
    logic [7:0]  wa;
    logic [31:0] wd;
    wen = bus.m_we;
    wa  = bus.m_addr;
    wd  = bus.m_wdata;
    @(posedge clk);
    #1;
    if (wen) mem[wa[7:2]] = wd;
  endtask

  // Reset across one edge; returns in cycle 0 with outputs settled.
  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h11 * (i + 1);

    rst          = 1'b1;
    bus.if_ready = 1'b1;
    bus.flush    = 1'b0;
    bus.flush_pc = '0;
    bus.halt     = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_funct3 = 3'b010;
    #2;

    // Reset state
    check("rst_if_valid", 32'(bus.if_valid), 0);
    check("rst_fq_count", 32'(bus.fq_count), 0);
    check("rst_if_instr", bus.if_instr, 0);
    check("rst_if_pc",    bus.if_pc, 0);

    // ---- 1: streaming fetch, if_ready=1 ----
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t1_c0_if_valid", 32'(bus.if_valid), 0);
    check("t1_c0_m_re",     32'(bus.m_re), 1);
    check("t1_c0_m_addr",   32'(bus.m_addr), 0);
    tick();
    check("t1_c1_if_valid", 32'(bus.if_valid), 1);
    check("t1_c1_if_pc",    bus.if_pc, 32'h0);
    check("t1_c1_if_instr", bus.if_instr, 32'h11);
    tick();
    check("t1_c2_if_pc",    bus.if_pc, 32'h4);
    check("t1_c2_if_instr", bus.if_instr, 32'h22);
    tick();
    check("t1_c3_if_pc",    bus.if_pc, 32'h8);
    check("t1_c3_if_instr", bus.if_instr, 32'h33);
    check("t1_c3_fq_count", 32'(bus.fq_count), 1);

    // ---- 2: back-pressure fills the queue, then drains in order ----
    bus.if_ready = 1'b0;
    reset_dut();
    repeat (4) tick();
    check("t2_c4_fq_count", 32'(bus.fq_count), 4);
    check("t2_c4_m_re",     32'(bus.m_re), 0);
    repeat (3) tick();
    check("t2_c7_fq_count", 32'(bus.fq_count), 4);
    check("t2_c7_m_re",     32'(bus.m_re), 0);
    check("t2_c7_if_pc",    bus.if_pc, 32'h0);
    tick();
    bus.if_ready = 1'b1;
    #1;
    check("t2_c8_if_valid", 32'(bus.if_valid), 1);
    check("t2_c8_if_pc",    bus.if_pc, 32'h0);
    check("t2_c8_m_re_full_deq", 32'(bus.m_re), 0);
    check("t2_c8_m_addr",   32'(bus.m_addr), 32'h10);
    tick();
    check("t2_c9_fq_count", 32'(bus.fq_count), 3);
    check("t2_c9_if_pc",    bus.if_pc, 32'h4);
    check("t2_c9_if_instr", bus.if_instr, 32'h22);
    tick();
    check("t2_c10_if_pc",   bus.if_pc, 32'h8);
    tick();
    check("t2_c11_if_pc",   bus.if_pc, 32'hC);
    check("t2_c11_if_instr", bus.if_instr, 32'h44);
    tick();
    check("t2_c12_if_pc",   bus.if_pc, 32'h10);
    check("t2_c12_if_instr", bus.if_instr, 32'h55);

    // ---- 3: flush together with a data load ----
    bus.if_ready = 1'b0;
    reset_dut();
    repeat (3) tick();
    check("t3_c3_fq_count", 32'(bus.fq_count), 3);
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h42;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h80;
    #1;
    check("t3_d_ack",   32'(bus.d_ack), 1);
    check("t3_d_rdata", bus.d_rdata, 32'h231);
    check("t3_m_addr",  32'(bus.m_addr), 32'h80);
    check("t3_m_we",    32'(bus.m_we), 0);
    tick();
    bus.flush    = 1'b0;
    bus.d_req    = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    check("t3_post_fq_count", 32'(bus.fq_count), 0);
    check("t3_post_if_valid", 32'(bus.if_valid), 0);
    check("t3_post_m_addr",   32'(bus.m_addr), 32'h40);
    check("t3_post_m_re",     32'(bus.m_re), 1);
    tick();
    check("t3_fetch_if_pc",    bus.if_pc, 32'h40);
    check("t3_fetch_if_instr", bus.if_instr, 32'h121);

    // ---- 4: starvation bound with continuous data requests ----
    bus.if_ready = 1'b1;
    reset_dut();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h20;
    #1;
    // Forced fetches expected in cycles 3 and 8.
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t4_c%0d_d_ack", i), 32'(bus.d_ack), (i == 3 || i == 8) ? 32'd0 : 32'd1);
      if (i == 3) begin
        check("t4_c3_m_re",   32'(bus.m_re), 1);
        check("t4_c3_m_addr", 32'(bus.m_addr), 0);
      end
      if (i == 4) begin
        check("t4_c4_if_valid", 32'(bus.if_valid), 1);
        check("t4_c4_if_pc",    bus.if_pc, 32'h0);
        check("t4_c4_if_instr", bus.if_instr, 32'h11);
        check("t4_c4_d_rdata",  bus.d_rdata, 32'h99);
      end
      if (i == 5) check("t4_c5_fq_count", 32'(bus.fq_count), 0);
      tick();
    end
    bus.d_req = 1'b0;

    // ---- 5: halt drains the queue, data path still works ----
    bus.if_ready = 1'b0;
    reset_dut();
    repeat (2) tick();
    check("t5_c2_fq_count", 32'(bus.fq_count), 2);
    bus.halt     = 1'b1;
    bus.if_ready = 1'b1;
    #1;
    check("t5_c2_m_re",   32'(bus.m_re), 0);
    check("t5_c2_if_pc",  bus.if_pc, 32'h0);
    tick();
    check("t5_c3_if_pc",     bus.if_pc, 32'h4);
    check("t5_c3_fq_count",  32'(bus.fq_count), 1);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h10;
    bus.d_wdata = 32'hDEADBEEF;
    #1;
    check("t5_st_d_ack",  32'(bus.d_ack), 1);
    check("t5_st_m_we",   32'(bus.m_we), 1);
    check("t5_st_m_re",   32'(bus.m_re), 0);
    check("t5_st_m_addr", 32'(bus.m_addr), 32'h10);
    tick();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    #1;
    check("t5_c4_if_valid", 32'(bus.if_valid), 0);
    check("t5_c4_fq_count", 32'(bus.fq_count), 0);
    check("t5_c4_m_addr",   32'(bus.m_addr), 32'h8);
    check("t5_c4_m_re",     32'(bus.m_re), 0);
    tick();
    check("t5_c5_if_valid", 32'(bus.if_valid), 0);
    check("t5_c5_m_addr",   32'(bus.m_addr), 32'h8);
    bus.d_req = 1'b1;
    #1;
    check("t5_ld_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    tick();
    bus.d_req    = 1'b0;
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h23;
    #1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("t5_flush_m_addr", 32'(bus.m_addr), 32'h20);
    check("t5_flush_m_re",   32'(bus.m_re), 0);
    bus.halt = 1'b0;
    #1;
    check("t5_unhalt_m_re", 32'(bus.m_re), 1);
    tick();
    check("t5_unhalt_if_pc",    bus.if_pc, 32'h20);
    check("t5_unhalt_if_instr", bus.if_instr, 32'h99);

    // ---- 6: asynchronous reset mid-stream ----
    bus.if_ready = 1'b0;
    reset_dut();
    repeat (3) tick();
    check("t6_pre_fq_count", 32'(bus.fq_count), 3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_if_valid", 32'(bus.if_valid), 0);
    check("t6_rst_fq_count", 32'(bus.fq_count), 0);
    check("t6_rst_if_pc",    bus.if_pc, 32'h0);
    check("t6_rst_if_instr", bus.if_instr, 32'h0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    check("t6_c0_if_valid", 32'(bus.if_valid), 0);
    check("t6_c0_m_addr",   32'(bus.m_addr), 0);
    tick();
    check("t6_c1_if_valid", 32'(bus.if_valid), 1);
    check("t6_c1_if_pc",    bus.if_pc, 32'h0);
    check("t6_c1_if_instr", bus.if_instr, 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
